// File: rtl/wts_scheduler_pkg.sv
// Shared constants and state encoding for the wave-RAM access scheduler.
package wts_scheduler_pkg;

  localparam int NUM_CH    = 5;
  localparam int NUM_SLOTS = 6;
  localparam int CPU_SLOT  = 5;
  localparam int CNT_W     = 3;

  // Round edge index of the commit edge: two drain clocks after the last slot.
  localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(NUM_SLOTS + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CPU,
    ST_DRAIN
  } state_e;

  function automatic logic [6:0] ch_field(input logic [NUM_CH*7-1:0] v,
                                          input logic [CNT_W-1:0]    n);
    return v[7*int'(n) +: 7];
  endfunction

endpackage

// File: rtl/wts_sample_bank.sv
// Per-channel shadow registers filled during a round, committed together on one strobe.
module wts_sample_bank
  import wts_scheduler_pkg::*;
(
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  cap_en,
  input  logic [CNT_W-1:0]      cap_idx,
  input  logic [7:0]            cap_data,
  input  logic                  commit,
  output logic [NUM_CH*8-1:0]   samples,
  output logic                  valid
);

  logic [7:0]          shadow_q [NUM_CH];
  logic [NUM_CH*8-1:0] samples_q;
  logic                valid_q;

  // NOTE: the shadow array is only five bytes of flops, not a RAM macro, so it is
  // reset like any other register; a real memory array would be left unreset.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= 8'h00;
      samples_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= commit;
      for (int i = 0; i < NUM_CH; i++) begin
        if (cap_en && cap_idx == CNT_W'(i)) shadow_q[i] <= cap_data;
        if (commit) samples_q[8*i +: 8] <= shadow_q[i];
      end
    end
  end

  assign samples = samples_q;
  assign valid   = valid_q;

endmodule

// File: rtl/wts_wave_ram_scheduler.sv
// Time-slots one wave RAM between five tone-generator fetches and one CPU access per round.
// Optional sticky overrun flag enabled by defining WTS_OVERRUN_DETECT_EN.
module wts_wave_ram_scheduler
  import wts_scheduler_pkg::*;
(
  input  logic                clk,
  input  logic                nreset,
  input  logic                active,
  input  logic [NUM_CH*7-1:0] ch_wave_address,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [2:0]          cpu_ch,
  input  logic [6:0]          cpu_address,
  input  logic [7:0]          cpu_wdata,
  output logic                cpu_ack,
  output logic [7:0]          cpu_rdata,
  output logic [9:0]          ram_address,
  output logic                ram_we,
  output logic [7:0]          ram_wdata,
  input  logic [7:0]          ram_rdata,
  output logic [NUM_CH*8-1:0] ch_sample,
  output logic                sample_valid,
  output logic                overrun,
  input  logic                overrun_clear
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       addr_q, addr_d;
  logic             we_q, we_d;
  logic [7:0]       wdata_q, wdata_d, rdata_q, rdata_d;
  logic             taken_q, taken_d, wr_q, wr_d, null_q, null_d, ack_q, ack_d;
  logic             cap_en, commit, ovr_set;
  logic [CNT_W-1:0] cap_idx;

  // NOTE: every output of this block gets a default before the case so that no
  // path leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    taken_d = taken_q;
    wr_d    = wr_q;
    null_d  = null_q;
    ack_d   = 1'b0;
    commit  = 1'b0;
    ovr_set = active && (state_q != ST_IDLE);
    // Read data lags the address register by two edges, so shadow n lands at edge n+2.
    cap_en  = (state_q != ST_IDLE) && (cnt_q >= CNT_W'(2)) && (cnt_q <= CNT_W'(NUM_SLOTS));
    cap_idx = cnt_q - CNT_W'(2);

    unique case (state_q)
      ST_IDLE: begin
        if (active) begin
          state_d = ST_FETCH;
          cnt_d   = CNT_W'(1);
          addr_d  = {3'd0, ch_field(ch_wave_address, 3'd0)};
          taken_d = 1'b0;
        end
      end
      ST_FETCH: begin
        addr_d = {cnt_q, ch_field(ch_wave_address, cnt_q)};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(CPU_SLOT - 1)) state_d = ST_CPU;
      end
      ST_CPU: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = ST_DRAIN;
        if (cpu_req) begin
          taken_d = 1'b1;
          wr_d    = cpu_we;
          null_d  = (cpu_ch > 3'(NUM_CH - 1));
          if (cpu_ch <= 3'(NUM_CH - 1)) begin
            addr_d  = {cpu_ch, cpu_address};
            we_d    = cpu_we;
            wdata_d = cpu_wdata;
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_q == LAST_EDGE) begin
          state_d = ST_IDLE;
          commit  = 1'b1;
          taken_d = 1'b0;
          if (taken_q) begin
            ack_d = 1'b1;
            if (null_q)   rdata_d = 8'h00;
            else if (!wr_q) rdata_d = ram_rdata;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      taken_q <= 1'b0;
      wr_q    <= 1'b0;
      null_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      taken_q <= taken_d;
      wr_q    <= wr_d;
      null_q  <= null_d;
      ack_q   <= ack_d;
    end
  end

  wts_sample_bank u_bank (
    .clk      (clk),
    .nreset   (nreset),
    .cap_en   (cap_en),
    .cap_idx  (cap_idx),
    .cap_data (ram_rdata),
    .commit   (commit),
    .samples  (ch_sample),
    .valid    (sample_valid)
  );

`ifdef WTS_OVERRUN_DETECT_EN
  logic ovr_q;

  // A set wins over a clear arriving on the same edge.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)            ovr_q <= 1'b0;
    else if (ovr_set)       ovr_q <= 1'b1;
    else if (overrun_clear) ovr_q <= 1'b0;
  end

  assign overrun = ovr_q;
`else
  logic unused_ovr;
  assign unused_ovr = ^{ovr_set, overrun_clear};
  assign overrun    = 1'b0;
`endif

  assign ram_address = addr_q;
  assign ram_we      = we_q;
  assign ram_wdata   = wdata_q;
  assign cpu_ack     = ack_q;
  assign cpu_rdata   = rdata_q;

endmodule

// File: tb/tb_wts_wave_ram_scheduler.sv
// Scoreboard bench for wts_wave_ram_scheduler with a two-edge-latency wave RAM model.
`timescale 1ns/1ps
module tb_wts_wave_ram_scheduler;

`ifdef WTS_OVERRUN_DETECT_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        nreset, active, cpu_req, cpu_we, overrun_clear;
  logic [34:0] ch_wave_address;
  logic [2:0]  cpu_ch;
  logic [6:0]  cpu_address;
  logic [7:0]  cpu_wdata, cpu_rdata, ram_wdata, ram_rdata;
  logic        cpu_ack, ram_we, sample_valid, overrun;
  logic [9:0]  ram_address;
  logic [39:0] ch_sample;

  int tests = 0;
  int fails = 0;

  logic [9:0]  exp_addr_q [$];
  logic [39:0] exp_smp_q  [$];
  logic [7:0]  exp_rd_q   [$];
  logic [7:0]  last_rd = 8'h00;
  logic [7:0]  wr_mem [int];

  wts_wave_ram_scheduler dut (
    .clk             (clk),
    .nreset          (nreset),
    .active          (active),
    .ch_wave_address (ch_wave_address),
    .cpu_req         (cpu_req),
    .cpu_we          (cpu_we),
    .cpu_ch          (cpu_ch),
    .cpu_address     (cpu_address),
    .cpu_wdata       (cpu_wdata),
    .cpu_ack         (cpu_ack),
    .cpu_rdata       (cpu_rdata),
    .ram_address     (ram_address),
    .ram_we          (ram_we),
    .ram_wdata       (ram_wdata),
    .ram_rdata       (ram_rdata),
    .ch_sample       (ch_sample),
    .sample_valid    (sample_valid),
    .overrun         (overrun),
    .overrun_clear   (overrun_clear)
  );

  always #5 clk = ~clk;

  // Unwritten RAM words hold the low byte of their own address.
  function automatic logic [7:0] ram_word(input logic [9:0] a);
    if (wr_mem.exists(int'(a))) return wr_mem[int'(a)];
    return a[7:0];
  endfunction

  always @(posedge clk) begin
    ram_rdata <= ram_word(ram_address);
    if (ram_we) wr_mem[int'(ram_address)] = ram_wdata;
  end

  task automatic push_round(input logic [34:0] a);
    logic [39:0] s;
    logic [9:0]  ra;
    for (int n = 0; n < 5; n++) begin
      ra = {3'(n), a[7*n +: 7]};
      exp_addr_q.push_back(ra);
      s[8*n +: 8] = ram_word(ra);
    end
    exp_smp_q.push_back(s);
  endtask

  task automatic chk_bit(input string name, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // Pulses active, then checks outputs after each edge E0..E8 against the scoreboard.
  task automatic run_round(input string tag, input bit exp_ack, input bit exp_we,
                           input logic [9:0] e5_addr, input logic [7:0] exp_wd);
    logic [9:0]  ea;
    logic [39:0] es;
    logic [7:0]  er;
    @(negedge clk); active = 1'b1;
    @(negedge clk); active = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      if (k <= 4) begin
        ea = exp_addr_q.pop_front();
        tests++;
        if (ram_address !== ea) begin
          fails++;
          $display("FAIL %s ram_address E%0d: got %h expected %h", tag, k, ram_address, ea);
        end
      end
      if (k == 5) begin
        tests++;
        if (ram_address !== e5_addr) begin
          fails++;
          $display("FAIL %s ram_address E5: got %h expected %h", tag, ram_address, e5_addr);
        end
        if (exp_we) begin
          tests++;
          if (ram_wdata !== exp_wd) begin
            fails++;
            $display("FAIL %s ram_wdata E5: got %h expected %h", tag, ram_wdata, exp_wd);
          end
        end
      end
      chk_bit($sformatf("%s ram_we E%0d", tag, k), ram_we, (k == 5) && exp_we);
      chk_bit($sformatf("%s sample_valid E%0d", tag, k), sample_valid, k == 7);
      chk_bit($sformatf("%s cpu_ack E%0d", tag, k), cpu_ack, (k == 7) && exp_ack);
      if (k == 7) begin
        es = exp_smp_q.pop_front();
        tests++;
        if (ch_sample !== es) begin
          fails++;
          $display("FAIL %s ch_sample: got %h expected %h", tag, ch_sample, es);
        end
        if (exp_ack) begin
          er = exp_rd_q.pop_front();
          tests++;
          if (cpu_rdata !== er) begin
            fails++;
            $display("FAIL %s cpu_rdata: got %h expected %h", tag, cpu_rdata, er);
          end
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic check_all_zero(input string tag);
    tests++;
    if ({ch_sample, ram_address, ram_wdata, cpu_rdata, sample_valid, cpu_ack, ram_we, overrun} !== '0) begin
      fails++;
      $display("FAIL %s outputs: got smp=%h addr=%h wd=%h rd=%h sv=%b ack=%b we=%b ovr=%b expected all 0",
               tag, ch_sample, ram_address, ram_wdata, cpu_rdata, sample_valid, cpu_ack, ram_we, overrun);
    end
  endtask

  localparam logic [34:0] BASE_ADDRS = {7'h14, 7'h13, 7'h12, 7'h14, 7'h10};

  task automatic test_reset();
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("post_reset_idle");
  endtask

  task automatic test_fetch();
    ch_wave_address = BASE_ADDRS;
    push_round(BASE_ADDRS);
    run_round("fetch", 1'b0, 1'b0, 10'h214, 8'h00);
  endtask

  task automatic test_cpu_write();
    logic [34:0] a;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_ch = 3'd2; cpu_address = 7'h05; cpu_wdata = 8'hA5;
    push_round(BASE_ADDRS);
    exp_rd_q.push_back(last_rd);
    run_round("cpu_wr", 1'b1, 1'b1, 10'h105, 8'hA5);
    cpu_req = 1'b0; cpu_we = 1'b0;
    a = BASE_ADDRS;
    a[20:14] = 7'h05;
    ch_wave_address = a;
    push_round(a);
    run_round("readback", 1'b0, 1'b0, 10'h214, 8'h00);
    tests++;
    if (ch_sample[23:16] !== 8'hA5) begin
      fails++;
      $display("FAIL readback ch2: got %h expected a5", ch_sample[23:16]);
    end
    ch_wave_address = BASE_ADDRS;
  endtask

  task automatic test_cpu_read();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_ch = 3'd2; cpu_address = 7'h05; cpu_wdata = 8'h3C;
    push_round(BASE_ADDRS);
    exp_rd_q.push_back(8'hA5);
    last_rd = 8'hA5;
    run_round("cpu_rd", 1'b1, 1'b0, 10'h105, 8'h00);
    cpu_req = 1'b0;
  endtask

  task automatic test_cpu_null();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_ch = 3'd6; cpu_address = 7'h33;
    push_round(BASE_ADDRS);
    exp_rd_q.push_back(8'h00);
    last_rd = 8'h00;
    run_round("cpu_null", 1'b1, 1'b0, 10'h214, 8'h00);
    cpu_req = 1'b0;
  endtask

  task automatic test_overrun();
    int valids = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sample_valid === 1'b1) valids++;
      active = (i % 6 == 0) && (i < 24);
    end
    tests++;
    if (valids != 2) begin
      fails++;
      $display("FAIL overrun rounds: got %0d sample_valid pulses expected 2", valids);
    end
    chk_bit("overrun set", overrun, OVR_EN);
    @(negedge clk); overrun_clear = 1'b1;
    @(negedge clk); overrun_clear = 1'b0;
    chk_bit("overrun cleared", overrun, 1'b0);
    // Ignored pulse and clear together on one edge: the set must win.
    @(negedge clk); active = 1'b1;
    @(negedge clk); active = 1'b0;
    repeat (2) @(negedge clk);
    active = 1'b1; overrun_clear = 1'b1;
    @(negedge clk); active = 1'b0; overrun_clear = 1'b0;
    chk_bit("overrun set+clear", overrun, OVR_EN);
    repeat (8) @(negedge clk);
    overrun_clear = 1'b1;
    @(negedge clk); overrun_clear = 1'b0;
    chk_bit("overrun final clear", overrun, 1'b0);
  endtask

  task automatic test_reset_mid();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_ch = 3'd2; cpu_address = 7'h05;
    @(negedge clk); active = 1'b1;
    @(negedge clk); active = 1'b0;
    repeat (3) @(negedge clk);
    chk_bit("mid ram_address nonzero", ram_address == 10'h193, 1'b1);
    nreset = 1'b0;
    #1;
    check_all_zero("reset_mid");
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 2) nreset = 1'b1;
      tests++;
      if (cpu_ack !== 1'b0 || sample_valid !== 1'b0) begin
        fails++;
        $display("FAIL reset_mid quiet %0d: got ack=%b sv=%b expected 0", i, cpu_ack, sample_valid);
      end
    end
    push_round(BASE_ADDRS);
    exp_rd_q.push_back(8'hA5);
    run_round("reset_mid_retry", 1'b1, 1'b0, 10'h105, 8'h00);
    cpu_req = 1'b0;
  endtask

  initial begin
    nreset = 1'b0; active = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_ch = 3'd0;
    cpu_address = 7'h00; cpu_wdata = 8'h00; overrun_clear = 1'b0;
    ch_wave_address = '0;
    test_reset();
    test_fetch();
    test_cpu_write();
    test_cpu_read();
    test_cpu_null();
    test_overrun();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
